// File: rtl/ram64_ctrl.sv
// ram64_ctrl: command sequencer in front of a single-port ram64.
// Accepts one valid/ready command at a time and turns it into ram64 accesses:
// read, write, block fill and forward block copy. Each command ends with a
// one-cycle rsp_valid pulse.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   command handshake (ready only in IDLE)
//   req_op                00 read, 01 write, 10 fill, 11 copy
//   req_addr/req_src      destination / copy source start address
//   req_len               fill/copy word count minus one
//   req_data              write data / fill pattern
//   rsp_valid/rsp_data    completion pulse and payload (held until next DONE)
//   busy                  a command is in progress
//   ram_address/ram_in/ram_load/ram_out   ram64 connection
//
// state  | meaning
// IDLE   | waiting for a command, req_ready=1
// RD     | single read, ram_out captured into rsp_data
// WR     | single write of the latched data
// FILL   | one write per cycle at addr+i, len+1 cycles
// CP_RD  | copy: read src+i into buf
// CP_WR  | copy: write buf to addr+i, advance i
// DONE   | rsp_valid pulse, back to IDLE
module ram64_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [ADDR_W-1:0] req_len,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    FILL  = 3'd3,
    CP_RD = 3'd4,
    CP_WR = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                load_raw;
  logic [ADDR_W:0]     len_p1;
  logic                last_word;

  // Word count reported for fill/copy; one bit wider so len=63 reports 64.
  assign len_p1    = {1'b0, len_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (i_q == len_q);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    src_d       = src_q;
    len_d       = len_q;
    data_d      = data_q;
    i_d         = i_q;
    buf_d       = buf_q;
    rsp_data_d  = rsp_data_q;
    ram_address = '0;
    ram_in      = '0;
    load_raw    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          src_d  = req_src;
          len_d  = req_len;
          data_d = req_data;
          i_d    = '0;
          case (req_op)
            2'b00:   state_d = RD;
            2'b01:   state_d = WR;
            2'b10:   state_d = FILL;
            default: state_d = CP_RD;
          endcase
        end
      end
      RD: begin
        ram_address = addr_q;
        rsp_data_d  = ram_out;
        state_d     = DONE;
      end
      WR: begin
        ram_address = addr_q;
        ram_in      = data_q;
        load_raw    = 1'b1;
        rsp_data_d  = data_q;
        state_d     = DONE;
      end
      FILL: begin
        ram_address = addr_q + i_q;
        ram_in      = data_q;
        load_raw    = 1'b1;
        i_d         = i_q + 1'b1;
        if (last_word) begin
          rsp_data_d = DATA_W'(len_p1);
          state_d    = DONE;
        end
      end
      CP_RD: begin
        ram_address = src_q + i_q;
        buf_d       = ram_out;
        state_d     = CP_WR;
      end
      CP_WR: begin
        ram_address = addr_q + i_q;
        ram_in      = buf_q;
        load_raw    = 1'b1;
        i_d         = i_q + 1'b1;
        if (last_word) begin
          rsp_data_d = DATA_W'(len_p1);
          state_d    = DONE;
        end else begin
          state_d    = CP_RD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      src_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      i_q        <= '0;
      buf_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      src_q      <= src_d;
      len_q      <= len_d;
      data_q     <= data_d;
      i_q        <= i_d;
      buf_q      <= buf_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Gating with reset_n keeps an aborted command from writing in the reset cycle.
  assign ram_load  = load_raw & reset_n;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;

endmodule
